// File: rtl/four_bit_division_if.sv
// Handshake and result bundle for the 8-by-4 restoring divider.
interface four_bit_division_if;
  logic       start;
  logic [7:0] in1;
  logic [3:0] in2;
  logic [7:0] out;
  logic [3:0] rem;
  logic       busy;
  logic       done;
  logic       div_zero;

  modport master (output start, in1, in2, input out, rem, busy, done, div_zero);
  modport slave  (input start, in1, in2, output out, rem, busy, done, div_zero);
endinterface

// File: rtl/four_bit_division.sv
// 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_DETECT_EN: divide-by-zero short-circuits straight to DONE.
module four_bit_division (
  input logic                 clk,
  input logic                 rst_n,
  four_bit_division_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [3:0] r;
  logic [7:0] q;
  logic [2:0] cnt;
  logic [7:0] out_q;
  logic [3:0] rem_q;
  logic       dz_q;

  logic [4:0] t;
  logic       ge;
  logic [3:0] r_nxt;
  logic       zero_fast;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_fast = (bus.in2 == 4'd0);
`else
  assign zero_fast = 1'b0;
`endif

  // Only R[3:0] is kept: for a nonzero divisor the remainder always fits,
  // and for a zero divisor only the low nibble ends up in rem.
  always_comb begin
    t     = {r, dvd[cnt]};
    ge    = (t >= {1'b0, dvs});
    r_nxt = ge ? 4'(t - {1'b0, dvs}) : t[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      out_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && zero_fast) begin
            out_q <= 8'hFF;
            rem_q <= bus.in1[3:0];
            dz_q  <= 1'b1;
            state <= DONE;
          end else if (bus.start) begin
            dvd   <= bus.in1;
            dvs   <= bus.in2;
            r     <= '0;
            q     <= '0;
            cnt   <= 3'd7;
            state <= RUN;
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= {q[6:0], ge};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            out_q <= {q[6:0], ge};
            rem_q <= r_nxt;
            dz_q  <= 1'b0;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = (state == RUN) || (state == DONE);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_four_bit_division.sv
// Bench for four_bit_division: vector table, corner sequences, exhaustive sweep.
module tb_four_bit_division;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         done_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  four_bit_division_if bus ();

  four_bit_division dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("quotient", int'(bus.out), int'(e.q));
        check("remainder", int'(bus.rem), int'(e.r));
        check("div_zero", int'(bus.div_zero), int'(e.dz));
        check("latency", cyc, e.done_cyc);
      end
    end
  end

  // Called at a negedge just before the edge that will accept start.
  task automatic push_exp(input logic [3:0] b, input logic [7:0] q, input logic [3:0] r);
    exp_t e;
    bit   fast;
    fast       = DZ_EN && (b == 4'd0);
    e.q        = q;
    e.r        = r;
    e.dz       = fast;
    e.done_cyc = cyc + 1 + (fast ? 1 : 8);
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] q, input logic [3:0] r, input bit push);
    @(negedge clk);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = 1'b1;
    if (push) push_exp(b, q, r);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in1   = 8'($urandom);
    bus.in2   = 4'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
      #1;
    end
    check("done_timeout", 1, 0);
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out"}, int'(bus.out), 0);
    check({tag, "_rem"}, int'(bus.rem), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_div_zero"}, int'(bus.div_zero), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   busy_cnt;
    logic [7:0] qq;
    logic [3:0] rr;

    vecs[0] = '{8'd143, 4'd11, 8'd13,  4'd0};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0};
    vecs[2] = '{8'd7,   4'd9,  8'd0,   4'd7};
    vecs[3] = '{8'd200, 4'd15, 8'd13,  4'd5};
    vecs[4] = '{8'h5A,  4'd0,  8'hFF,  4'hA};
    vecs[5] = '{8'd100, 4'd7,  8'd14,  4'd2};
    vecs[6] = '{8'd0,   4'd5,  8'd0,   4'd0};
    vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0};
    vecs[8] = '{8'd1,   4'd1,  8'd1,   4'd0};
    vecs[9] = '{8'd128, 4'd3,  8'd42,  4'd2};

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // 143/11: done 8 cycles after start, busy for 9 cycles
    start_op(8'd143, 4'd11, 8'd13, 4'd0, 1'b1);
    busy_cnt = int'(bus.busy);
    repeat (12) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
    end
    check("busy_cycles", busy_cnt, 9);
    wait_done();

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);
      wait_done();
    end

    // Results hold while idle
    repeat (3) @(negedge clk);
    check("hold_out", int'(bus.out), 42);
    check("hold_rem", int'(bus.rem), 2);

    // Reset mid-run aborts asynchronously; start on the release edge is taken
    start_op(8'd100, 4'd7, 8'd0, 4'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    repeat (2) @(negedge clk);
    check("reset_no_done", int'(bus.done), 0);
    rst_n     = 1'b1;
    bus.in1   = 8'd100;
    bus.in2   = 4'd7;
    bus.start = 1'b1;
    push_exp(4'd7, 8'd14, 4'd2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Start during RUN is ignored; next start in first IDLE cycle runs
    start_op(8'd50, 4'd5, 8'd10, 4'd0, 1'b1);
    repeat (2) @(negedge clk);
    bus.in1   = 8'd99;
    bus.in2   = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    start_op(8'd99, 4'd3, 8'd33, 4'd0, 1'b1);
    wait_done();

    // Exhaustive nonzero-divisor sweep, back to back
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        qq = 8'(a / b);
        rr = 4'(a % b);
        start_op(8'(a), 4'(b), qq, rr, 1'b1);
        wait_done();
      end
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
